// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Merges the per-pipe execute result streams onto one registered writeback
//   channel. Pipes are served round-robin starting at grant_ptr. A squash
//   discards every result younger than the squashing instruction, both those
//   still waiting at the pipe inputs and the one held in the output register.
//   Age is always measured relative to head_seq_num, so sequence-number
//   wrap-around needs no wide compares.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ex_val / ex_rdy   per-pipe result handshake
//   ex_seq_num, ex_pc, ex_waddr, ex_wdata, ex_wen
//                     packed per-pipe result fields (pipe i at slice i)
//   head_seq_num      oldest uncommitted sequence number (age reference)
//   squash_val/_seq   squash notification and squashing sequence number
//   wb_val / wb_rdy   output entry handshake
//   wb_seq_num, wb_pc, wb_waddr, wb_wdata, wb_wen
//                     output entry fields
//   grant_ptr         current round-robin priority pointer
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int p_num_pipes      = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [p_num_pipes-1:0]                 ex_val,
  output logic [p_num_pipes-1:0]                 ex_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0]  ex_seq_num,
  input  logic [p_num_pipes*32-1:0]              ex_pc,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0] ex_waddr,
  input  logic [p_num_pipes*32-1:0]              ex_wdata,
  input  logic [p_num_pipes-1:0]                 ex_wen,
  input  logic [p_seq_num_bits-1:0]              head_seq_num,
  input  logic                                   squash_val,
  input  logic [p_seq_num_bits-1:0]              squash_seq_num,
  output logic                                   wb_val,
  input  logic                                   wb_rdy,
  output logic [p_seq_num_bits-1:0]              wb_seq_num,
  output logic [31:0]                            wb_pc,
  output logic [p_phys_addr_bits-1:0]            wb_waddr,
  output logic [31:0]                            wb_wdata,
  output logic                                   wb_wen,
  output logic [$clog2(p_num_pipes)-1:0]         grant_ptr
);

  localparam int lp_ptr_w = $clog2(p_num_pipes);

  // Head-relative age; the subtraction wraps naturally at the field width.
  function automatic logic [p_seq_num_bits-1:0] age_of(
    input logic [p_seq_num_bits-1:0] x,
    input logic [p_seq_num_bits-1:0] head
  );
    return x - head;
  endfunction

  // Unpacked views of the per-pipe fields.
  logic [p_seq_num_bits-1:0]   seq_a   [p_num_pipes];
  logic [31:0]                 pc_a    [p_num_pipes];
  logic [p_phys_addr_bits-1:0] waddr_a [p_num_pipes];
  logic [31:0]                 wdata_a [p_num_pipes];

  always_comb begin
    for (int i = 0; i < p_num_pipes; i++) begin
      seq_a[i]   = ex_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
      pc_a[i]    = ex_pc[i*32 +: 32];
      waddr_a[i] = ex_waddr[i*p_phys_addr_bits +: p_phys_addr_bits];
      wdata_a[i] = ex_wdata[i*32 +: 32];
    end
  end

  logic [p_seq_num_bits-1:0] squash_age;
  logic [p_num_pipes-1:0]    doomed;
  logic [p_num_pipes-1:0]    cand;
  logic                      kill_held;
  logic                      can_load;

  // Equal age is the squashing instruction itself, which survives.
  always_comb begin
    squash_age = age_of(squash_seq_num, head_seq_num);
    for (int i = 0; i < p_num_pipes; i++) begin
      doomed[i] = squash_val & ex_val[i] &
                  (age_of(seq_a[i], head_seq_num) > squash_age);
    end
    cand      = ex_val & ~doomed;
    kill_held = squash_val & wb_val &
                (age_of(wb_seq_num, head_seq_num) > squash_age);
    can_load  = ~wb_val | wb_rdy | kill_held;
  end

  logic                win_found;
  logic [lp_ptr_w-1:0] win_idx;
  logic [lp_ptr_w-1:0] grant_ptr_nxt;
  logic                load;
  logic [p_num_pipes-1:0] grant_vec;

  // Rotating search starting at grant_ptr; the first candidate hit wins.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      idx = int'(grant_ptr) + k;
      if (idx >= p_num_pipes) idx = idx - p_num_pipes;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = lp_ptr_w'(idx);
      end
    end
    grant_ptr_nxt = (int'(win_idx) == p_num_pipes - 1) ? '0 : win_idx + 1'b1;
    load          = win_found & can_load;
    for (int i = 0; i < p_num_pipes; i++) begin
      grant_vec[i] = load && (int'(win_idx) == i);
    end
  end

  // Doomed pipes are always drained so a squashed result never stalls a pipe.
  assign ex_rdy = rst ? '0 : (doomed | grant_vec);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_val     <= 1'b0;
      wb_seq_num <= '0;
      wb_pc      <= '0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_wen     <= 1'b0;
      grant_ptr  <= '0;
    end else if (load) begin
      wb_val     <= 1'b1;
      wb_seq_num <= seq_a[win_idx];
      wb_pc      <= pc_a[win_idx];
      wb_waddr   <= waddr_a[win_idx];
      wb_wdata   <= wdata_a[win_idx];
      wb_wen     <= ex_wen[win_idx];
      grant_ptr  <= grant_ptr_nxt;
    end else if ((wb_val && wb_rdy) || kill_held) begin
      // A killed entry is dropped whether or not wb_rdy is asserted.
      wb_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Scoreboard bench for wb_arbiter. A reference process evaluates each cycle
//   from the arbitration rules (ages, candidate list, rotating priority) and
//   queues the entry expected on the writeback channel; a monitor compares the
//   channel against the queue head every cycle and retires entries on accept
//   or on squash.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int N = 4;
  localparam int S = 5;
  localparam int A = 6;
  localparam int P = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         ex_val, ex_rdy, ex_wen;
  logic [N*S-1:0]       ex_seq_num;
  logic [N*32-1:0]      ex_pc, ex_wdata;
  logic [N*A-1:0]       ex_waddr;
  logic [S-1:0]         head_seq_num, squash_seq_num;
  logic                 squash_val;
  logic                 wb_val, wb_rdy, wb_wen;
  logic [S-1:0]         wb_seq_num;
  logic [31:0]          wb_pc, wb_wdata;
  logic [A-1:0]         wb_waddr;
  logic [P-1:0]         grant_ptr;

  wb_arbiter #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(A)) dut (
    .clk(clk), .rst(rst),
    .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_seq_num(ex_seq_num), .ex_pc(ex_pc),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen),
    .head_seq_num(head_seq_num), .squash_val(squash_val),
    .squash_seq_num(squash_seq_num),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_seq_num(wb_seq_num), .wb_pc(wb_pc),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wen(wb_wen),
    .grant_ptr(grant_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [S-1:0]  seq;
    logic [31:0]   pc;
    logic [A-1:0]  waddr;
    logic [31:0]   wdata;
    logic          wen;
  } entry_t;

  entry_t q[$];
  int     exp_ptr = 0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Distance from the head, modulo the sequence space.
  function automatic int age(input logic [S-1:0] x);
    return (int'(x) - int'(head_seq_num) + (1 << S)) % (1 << S);
  endfunction

  function automatic bit younger(input logic [S-1:0] x);
    return age(x) > age(squash_seq_num);
  endfunction

  // Reference step: who is doomed, who wins, what gets loaded.
  // The monitor has already retired the held entry if it left this cycle,
  // so an empty queue means the output register is free to load.
  task automatic model_step();
    logic [N-1:0] exp_rdy;
    int w;
    int idx;
    entry_t e;
    exp_rdy = '0;
    w = -1;
    for (int i = 0; i < N; i++)
      if (squash_val && ex_val[i] && younger(ex_seq_num[i*S +: S])) exp_rdy[i] = 1'b1;
    for (int k = 0; k < N; k++) begin
      idx = (exp_ptr + k) % N;
      if (w < 0 && ex_val[idx] && !exp_rdy[idx]) w = idx;
    end
    if (w >= 0 && q.size() == 0) begin
      exp_rdy[w] = 1'b1;
      e.seq   = ex_seq_num[w*S +: S];
      e.pc    = ex_pc[w*32 +: 32];
      e.waddr = ex_waddr[w*A +: A];
      e.wdata = ex_wdata[w*32 +: 32];
      e.wen   = ex_wen[w];
      q.push_back(e);
      exp_ptr = (w + 1) % N;
    end
    check("ex_rdy", 64'(ex_rdy), 64'(exp_rdy));
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) model_step();
  end

  // Monitor: compares the channel with the queue head, retires on accept/kill.
  always @(negedge clk) begin
    if (!rst) begin
      check("wb_val", 64'(wb_val), 64'(q.size() != 0));
      check("grant_ptr", 64'(grant_ptr), 64'(exp_ptr));
      if (wb_val && q.size() != 0) begin
        check("wb_seq_num", 64'(wb_seq_num), 64'(q[0].seq));
        check("wb_pc",      64'(wb_pc),      64'(q[0].pc));
        check("wb_waddr",   64'(wb_waddr),   64'(q[0].waddr));
        check("wb_wdata",   64'(wb_wdata),   64'(q[0].wdata));
        check("wb_wen",     64'(wb_wen),     64'(q[0].wen));
      end
      if (q.size() != 0 && (wb_rdy || (squash_val && younger(q[0].seq))))
        void'(q.pop_front());
    end
  end

  task automatic set_pipe(input int i, input logic [S-1:0] seq,
                          input logic [31:0] wdata);
    ex_val[i]            = 1'b1;
    ex_seq_num[i*S +: S] = seq;
    ex_pc[i*32 +: 32]    = 32'h1000 + 32'(i * 4) + 32'(seq);
    ex_waddr[i*A +: A]   = A'(i + 8);
    ex_wdata[i*32 +: 32] = wdata;
    ex_wen[i]            = 1'b1;
  endtask

  task automatic idle();
    ex_val = '0; ex_wen = '0; ex_seq_num = '0; ex_pc = '0;
    ex_waddr = '0; ex_wdata = '0; squash_val = 1'b0; squash_seq_num = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; idle(); head_seq_num = '0; wb_rdy = 1'b0;
    ex_val = '1;
    #2;
    check("rst_wb_val", 64'(wb_val), 64'd0);
    check("rst_grant_ptr", 64'(grant_ptr), 64'd0);
    check("rst_wb_wdata", 64'(wb_wdata), 64'd0);
    check("rst_ex_rdy", 64'(ex_rdy), 64'd0);
    step(2);
    rst = 1'b0; ex_val = '0;
    step(1);

    // Round robin: all pipes valid, sink always ready.
    for (int i = 0; i < N; i++) set_pipe(i, S'(i + 1), 32'hA000_0000 + 32'(i));
    wb_rdy = 1'b1;
    step(5);
    idle();
    step(2);

    // Backpressure: pointer is now 1, so pipe 2 wins over pipe 3.
    set_pipe(2, 5'd7, 32'hDEADBEEF);
    set_pipe(3, 5'd9, 32'h3333_3333);
    wb_rdy = 1'b0;
    step(1);
    ex_val[2] = 1'b0;
    step(3);
    check("bp_hold_seq", 64'(wb_seq_num), 64'd7);
    check("bp_hold_data", 64'(wb_wdata), 64'hDEADBEEF);
    wb_rdy = 1'b1;
    step(1);
    check("bp_next_seq", 64'(wb_seq_num), 64'd9);
    idle();
    step(2);

    // Squash of the held entry: age 4 vs squash age 3 -> dropped.
    head_seq_num = 5'd30; wb_rdy = 1'b0;
    set_pipe(0, 5'd2, 32'h2222_0000);
    step(1);
    idle(); squash_val = 1'b1; squash_seq_num = 5'd1;
    step(1);
    squash_val = 1'b0;
    check("sq_held_drop", 64'(wb_val), 64'd0);
    // Equal age: entry kept.
    set_pipe(0, 5'd1, 32'h1111_0000);
    step(1);
    idle(); squash_val = 1'b1; squash_seq_num = 5'd1;
    step(1);
    squash_val = 1'b0;
    check("sq_held_keep", 64'(wb_val), 64'd1);
    wb_rdy = 1'b1;
    step(2);

    // Squash of inputs across the wrap point.
    head_seq_num = 5'd28;
    set_pipe(0, 5'd31, 32'h0000_0031);
    set_pipe(1, 5'd3,  32'h0000_0003);
    squash_val = 1'b1; squash_seq_num = 5'd0;
    #3;
    check("sq_in_rdy", 64'(ex_rdy), 64'h3);
    step(1);
    idle();
    check("sq_in_seq", 64'(wb_seq_num), 64'd31);
    step(1);

    // Sparse: move pointer to 1 via pipe 0, then only pipe 3 requests.
    set_pipe(0, 5'd29, 32'h0);
    step(1);
    idle(); set_pipe(3, 5'd30, 32'h3030_3030);
    step(1);
    idle();
    check("sparse_ptr", 64'(grant_ptr), 64'd0);
    step(2);

    // Asynchronous reset mid-transaction with a held entry.
    wb_rdy = 1'b0;
    set_pipe(1, 5'd29, 32'h5555_5555);
    step(1);
    idle();
    step(1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_wb_val", 64'(wb_val), 64'd0);
    check("midrst_grant_ptr", 64'(grant_ptr), 64'd0);
    q.delete(); exp_ptr = 0;
    step(1);
    rst = 1'b0;
    step(1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      head_seq_num = S'($urandom);
      for (int i = 0; i < N; i++) begin
        ex_val[i]            = 1'($urandom_range(0, 1));
        ex_seq_num[i*S +: S] = S'($urandom);
        ex_pc[i*32 +: 32]    = $urandom;
        ex_waddr[i*A +: A]   = A'($urandom);
        ex_wdata[i*32 +: 32] = $urandom;
        ex_wen[i]            = 1'($urandom_range(0, 1));
      end
      wb_rdy         = ($urandom_range(0, 9) < 7);
      squash_val     = ($urandom_range(0, 9) < 2);
      squash_seq_num = S'($urandom);
      step(1);
    end

    idle(); wb_rdy = 1'b1;
    step(4);
    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
